// File: rtl/cru_master.sv
// cru_master: TI-style CRU bus initiator serializing 1-16 bit LDCR/STCR-like transfers (define CRU_READBACK_VERIFY_EN for write readback verification)
module cru_master #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rw,
  input  logic [0:14] base_addr,
  input  logic [0:4]  count,
  input  logic [0:15] wdata,
  output logic [0:15] rdata,
  output logic        busy,
  output logic        done,
  output logic        verify_err,
  output logic [0:14] cru_addr,
  output logic        cru_clk,
  output logic        cru_out,
  output logic        memen,
  output logic        ph3,
  input  logic        cru_in
);
`ifdef CRU_READBACK_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, ARM, SETUP, STROBE, HOLD, DONE} state_t;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [14:0]      r_addr;
  logic [15:0]      r_wd, r_rdata;
  logic [3:0]       r_k, r_last;
  logic             r_rw, r_vrd, r_verr;
  logic             w_last, w_rd, w_phase, w_vnext;
  assign w_last     = r_cnt == CNT_W'(CLK_DIV - 1);
  assign w_rd       = r_rw | r_vrd;
  assign w_phase    = r_state inside {SETUP, STROBE, HOLD};
  assign w_vnext    = VERIFY && !r_rw && !r_vrd;
  assign busy       = w_phase || r_state == ARM;
  assign done       = r_state == DONE;
  assign cru_clk    = !(r_state == STROBE && !w_rd);
  assign ph3        = !(r_state == STROBE && w_rd);
  assign memen      = w_phase && w_rd;
  assign cru_addr   = r_addr;
  assign cru_out    = r_wd[r_k];
  assign rdata      = r_rdata;
  assign verify_err = r_verr;
  // State register; reset aborts any transfer without a done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Next state: each bus phase lasts CLK_DIV cycles, a verified write bit inserts a read bit cycle after HOLD
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? ARM : IDLE;
      ARM:     w_next = SETUP;
      SETUP:   w_next = w_last ? STROBE : SETUP;
      STROBE:  w_next = w_last ? HOLD : STROBE;
      HOLD:    w_next = !w_last ? HOLD : (!w_vnext && r_k == r_last) ? DONE : SETUP;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // Transfer datapath: capture on accept, sample cru_in at the last edge of a read STROBE, advance address after HOLD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wd    <= '0;
      r_rdata <= '0;
      r_k     <= '0;
      r_last  <= '0;
      r_rw    <= 1'b0;
      r_vrd   <= 1'b0;
      r_verr  <= 1'b0;
    end else begin
      r_cnt <= (w_phase && !w_last) ? r_cnt + CNT_W'(1) : '0;
      if (r_state == IDLE && start) begin
        r_rw    <= rw;
        r_addr  <= base_addr;
        r_last  <= 4'(count - 5'd1);
        r_wd    <= wdata;
        r_rdata <= '0;
        r_verr  <= 1'b0;
        r_k     <= '0;
        r_vrd   <= 1'b0;
      end
      if (r_state == STROBE && w_last && w_rd) begin
        r_rdata[r_k] <= cru_in === 1'b1;
        if (r_vrd && (cru_in !== r_wd[r_k])) r_verr <= 1'b1;
      end
      if (r_state == HOLD && w_last) begin
        r_vrd <= w_vnext;
        if (!w_vnext && r_k != r_last) begin
          r_k    <= r_k + 4'd1;
          r_addr <= r_addr + 15'd1;
        end
      end
    end
  end
endmodule
